regfile_ctx: RTL and testbench
==============================

// Module: regfile_ctx
// PURPOSE
//  Parametrised multi-read-port register file; successor to the fixed 32x32 two-read-port bank.
//  Adds async reset, write-to-read bypass, a hardwired zero register and a frame-pointer tap.
//  Adds a save handshake that stores the interrupted PC into a dedicated register, and a
//  sequenced bulk clear. Sits between decode (read ports) and writeback (write port).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD    2   number of independent read ports (1..4)
//  ZERO_REG  31  index hardwired to zero: reads give 0, writes are dropped
//  FP_REG    29  index driven continuously on FP
//  SAVE_REG  30  index written by the save handshake
//  BYPASS    1   1: a read of the address written this cycle returns WrData
// PORTS
//  Clock     in   1              rising-edge clock
//  Reset_n   in   1              asynchronous, active-low reset
//  RdAddr    in   NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
//  RdData    out  NUM_RD*DATA_W  packed read data, combinational from RdAddr
//  WrEn      in   1              write strobe
//  WrAddr    in   ADDR_W         write address
//  WrData    in   DATA_W         write data
//  SaveReq   in   1              level request: store SavePC into SAVE_REG
//  SavePC    in   DATA_W         PC value to save
//  SaveAck   out  1              one-cycle pulse: save committed
//  ClearReq  in   1              one-cycle pulse: zero every register
//  Busy      out  1              high while the clear sequence runs
//  FP        out  DATA_W         contents of FP_REG (bypass rules apply)
//  DbgAddr   in   ADDR_W         debug read address
//  DbgData   out  DATA_W         contents at DbgAddr (no bypass)
// BEHAVIOUR
//  Reset (Reset_n=0, async): all registers 0; state IDLE; SaveAck=0; Busy=0; clear index 0.
//  Reads: combinational. ZERO_REG always reads 0. With BYPASS=1 and WrEn accepted with
//   WrAddr==RdAddr[k] (and not ZERO_REG), RdData[k]=WrData in the same cycle. Otherwise the
//   stored value is returned.
//  Writes: commit on the rising edge; one-cycle latency. A write to ZERO_REG has no effect.
//  FSM states: IDLE, SAVE_ACK, CLEAR.
//   IDLE: ClearReq -> CLEAR (takes priority over SaveReq). Otherwise, SaveReq=1 writes
//    SavePC to SAVE_REG at this edge -> SAVE_ACK. Normal writes are accepted.
//   SAVE_ACK: SaveAck=1 for exactly this cycle -> IDLE. Normal writes are accepted.
//    If SaveReq is still high when IDLE is re-entered, a second save occurs.
//   CLEAR: Busy=1. One register is zeroed per cycle, idx 0..DEPTH-1, taking DEPTH cycles.
//    After the last index -> IDLE. WrEn, SaveReq and ClearReq are ignored, and there is
//    no bypass. A held SaveReq is serviced in the first IDLE cycle after CLEAR.
//  Save and WrEn in the same cycle: if WrAddr==SAVE_REG the save wins and WrData is
//   dropped; otherwise both commit at the same edge.
//  Bypass during a save: a read of SAVE_REG returns SavePC in the save cycle.
//  Reset mid-CLEAR or mid-save: every register zeroed immediately; state IDLE; no ack.
//  No arithmetic is performed; the clear index wraps at DEPTH and is never used beyond DEPTH-1.
// STRUCTURE
//  Shared package regfile_pkg: state encoding localparams (IDLE=2'd0, SAVE_ACK=2'd1,
//   CLEAR=2'd2) and default index constants (ZERO_REG, FP_REG, SAVE_REG).
//  One sub-module, regfile_rdport, instantiated NUM_RD times plus once for FP. It handles
//   the zero mask and the bypass mux. Storage and the FSM live in the top level.
// TESTING
//  1 Reset, then read all indices -> all 0; Busy=0; SaveAck=0.
//  2 Write r1=102 with RdAddr0=1 in the same cycle -> RdData0=102 combinationally (BYPASS=1);
//    next cycle, with WrEn=0 -> still 102.
//  3 Write r31=0xDEAD -> reads of 31 return 0; DbgData at 31 = 0.
//  4 SaveReq=1 with SavePC=0x40 and WrEn to r30=0x99 in the same cycle -> r30=0x40,
//    SaveAck pulses the next cycle; drop SaveReq -> no second ack.
//  5 Fill r0..r31, pulse ClearReq -> Busy=1 for 32 cycles; writes in between are ignored;
//    afterwards all registers are 0 and Busy=0.
//  6 Assert Reset_n=0 at cycle 10 of a clear with SaveReq held -> all 0 and Busy=0
//    immediately; after release, the save completes and r30=SavePC.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the context register file: FSM states and default register indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    // Controller states: normal operation, one-cycle save acknowledge, bulk clear sweep
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SAVE_ACK = 2'd1,
        CLEAR    = 2'd2
    } state_e;

    localparam int DEF_ZERO_REG = 31;
    localparam int DEF_FP_REG   = 29;
    localparam int DEF_SAVE_REG = 30;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero-register mask plus write/save bypass onto the stored value.
// Latency: 0 cycles, purely combinational from the address and bypass inputs.
// Backpressure: none; the port always answers.
module regfile_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              wr_vld_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    input  logic              sv_vld_i,
    input  logic [ADDR_W-1:0] sv_addr_i,
    input  logic [DATA_W-1:0] sv_dat_i,
    output logic [DATA_W-1:0] rd_dat_o
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    // Pick save data over normal write data over storage; the zero register always reads 0
    always_comb begin
        rd_dat_o = stored_i;
        if (BYPASS != 0 && wr_vld_i && wr_addr_i == rd_addr_i) begin
            rd_dat_o = wr_dat_i;
        end
        if (BYPASS != 0 && sv_vld_i && sv_addr_i == rd_addr_i) begin
            rd_dat_o = sv_dat_i;
        end
        if (rd_addr_i == ZERO_A) begin
            rd_dat_o = '0;
        end
    end

endmodule

// File: rtl/regfile_ctx.sv
// Multi-read-port register file with PC save handshake, sequenced bulk clear and FP/debug taps.
// Latency: reads combinational (with same-cycle bypass), writes and saves commit at the next edge.
// Backpressure: Busy high during the clear sweep, when writes, saves and clear requests are ignored.
module regfile_ctx
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int FP_REG   = DEF_FP_REG,
    parameter int SAVE_REG = DEF_SAVE_REG,
    parameter int BYPASS   = 1
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    input  logic                     WrEn,
    input  logic [ADDR_W-1:0]        WrAddr,
    input  logic [DATA_W-1:0]        WrData,
    input  logic                     SaveReq,
    input  logic [DATA_W-1:0]        SavePC,
    output logic                     SaveAck,
    input  logic                     ClearReq,
    output logic                     Busy,
    output logic [DATA_W-1:0]        FP,
    input  logic [ADDR_W-1:0]        DbgAddr,
    output logic [DATA_W-1:0]        DbgData
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] FP_A   = ADDR_W'(FP_REG);
    localparam logic [ADDR_W-1:0] SAVE_A = ADDR_W'(SAVE_REG);

    logic [DATA_W-1:0] mem_q [DEPTH];
    state_e            state_q;
    logic [ADDR_W-1:0] clr_idx_q;
    logic [ADDR_W-1:0] clr_idx_d;
    logic              busy_q;
    logic              ack_q;

    logic              save_go;
    logic              wr_go;

    // A save only starts from IDLE and loses to a clear request; it overrides a write to the same slot
    assign save_go   = (state_q == IDLE) && !ClearReq && SaveReq;
    assign wr_go     = WrEn && (state_q != CLEAR) && (WrAddr != ZERO_A) &&
                       !(save_go && (WrAddr == SAVE_A));
    assign clr_idx_d = clr_idx_q + 1'b1;

    assign Busy    = busy_q;
    assign SaveAck = ack_q;
    assign DbgData = mem_q[DbgAddr];

    // Storage: clear sweep zeroes one slot per cycle, otherwise normal write and save commit together
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            mem_q[clr_idx_q] <= '0;
        end else begin
            if (wr_go) begin
                mem_q[WrAddr] <= WrData;
            end
            if (save_go) begin
                mem_q[SAVE_A] <= SavePC;
            end
        end
    end

    // Controller FSM with registered Busy and SaveAck
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ClearReq) begin
                        state_q   <= CLEAR;
                        clr_idx_q <= '0;
                        busy_q    <= 1'b1;
                    end else if (SaveReq) begin
                        state_q <= SAVE_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                SAVE_ACK: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
                CLEAR: begin
                    clr_idx_q <= clr_idx_d;
                    if (clr_idx_q == '1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    // Decode-side read ports
    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            assign addr = RdAddr[k*ADDR_W +: ADDR_W];
            regfile_rdport #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rd (
                .rd_addr_i (addr),
                .stored_i  (mem_q[addr]),
                .wr_vld_i  (wr_go),
                .wr_addr_i (WrAddr),
                .wr_dat_i  (WrData),
                .sv_vld_i  (save_go),
                .sv_addr_i (SAVE_A),
                .sv_dat_i  (SavePC),
                .rd_dat_o  (RdData[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Frame-pointer tap follows the same bypass rules as a read port
    regfile_rdport #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_fp (
        .rd_addr_i (FP_A),
        .stored_i  (mem_q[FP_A]),
        .wr_vld_i  (wr_go),
        .wr_addr_i (WrAddr),
        .wr_dat_i  (WrData),
        .sv_vld_i  (save_go),
        .sv_addr_i (SAVE_A),
        .sv_dat_i  (SavePC),
        .rd_dat_o  (FP)
    );

endmodule

// File: tb/tb_regfile_ctx.sv
// Self-checking bench for regfile_ctx: directed scenarios plus a randomized run against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_ctx;

    logic        Clock;
    logic        Reset_n;
    logic [9:0]  RdAddr;
    logic [63:0] RdData;
    logic        WrEn;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic        SaveReq;
    logic [31:0] SavePC;
    logic        SaveAck;
    logic        ClearReq;
    logic        Busy;
    logic [31:0] FP;
    logic [4:0]  DbgAddr;
    logic [31:0] DbgData;

    regfile_ctx dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .WrEn     (WrEn),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .SaveReq  (SaveReq),
        .SavePC   (SavePC),
        .SaveAck  (SaveAck),
        .ClearReq (ClearReq),
        .Busy     (Busy),
        .FP       (FP),
        .DbgAddr  (DbgAddr),
        .DbgData  (DbgData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: register contents, cycles of clear left, and whether this cycle is the ack cycle
    logic [31:0] mem_m [32];
    int          clear_left;
    bit          ack_now;
    int          compared;
    int          mismatched;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_save_now();
        return (clear_left == 0) && !ack_now && !ClearReq && SaveReq;
    endfunction

    function automatic logic [31:0] model_read(input int a, input bit byp);
        if (a == 31) return 32'h0;
        if (byp && clear_left == 0) begin
            if (model_save_now() && a == 30) return SavePC;
            if (WrEn && int'(WrAddr) == a) return WrData;
        end
        return mem_m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
        clear_left = 0;
        ack_now    = 1'b0;
    endtask

    task automatic model_edge();
        bit sv;
        sv = model_save_now();
        if (clear_left > 0) begin
            mem_m[32 - clear_left] = 32'h0;
            clear_left--;
        end else begin
            if (WrEn && WrAddr != 5'd31 && !(sv && WrAddr == 5'd30)) mem_m[WrAddr] = WrData;
            if (sv) mem_m[30] = SavePC;
            if (ack_now) begin
                ack_now = 1'b0;
            end else if (ClearReq) begin
                clear_left = 32;
            end else if (SaveReq) begin
                ack_now = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("busy", {31'b0, Busy}, {31'b0, clear_left > 0});
        check("ack", {31'b0, SaveAck}, {31'b0, ack_now});
        check("rd0", RdData[31:0], model_read(int'(RdAddr[4:0]), 1'b1));
        check("rd1", RdData[63:32], model_read(int'(RdAddr[9:5]), 1'b1));
        check("fp", FP, model_read(29, 1'b1));
        check("dbg", DbgData, model_read(int'(DbgAddr), 1'b0));
    endtask

    // One clock: compare mid-cycle, then advance the model on the edge
    task automatic step();
        @(negedge Clock);
        check_outputs();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_busy", {31'b0, Busy}, 32'h0);
        check("rst_ack", {31'b0, SaveAck}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            DbgAddr = 5'(i);
            #1;
            check("rst_dbg", DbgData, 32'h0);
        end
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        compared   = 0;
        mismatched = 0;
        RdAddr = '0; WrEn = 0; WrAddr = '0; WrData = '0;
        SaveReq = 0; SavePC = '0; ClearReq = 0; DbgAddr = '0;

        // 1: reset then read every index
        do_reset();
        for (int i = 0; i < 32; i++) begin
            RdAddr = {5'(31 - i), 5'(i)}; DbgAddr = 5'(i);
            step();
        end

        // 2: same-cycle bypass of r1, then stored value
        WrEn = 1; WrAddr = 5'd1; WrData = 32'd102; RdAddr = {5'd0, 5'd1};
        #1;
        check("t2_bypass", RdData[31:0], 32'd102);
        step();
        WrEn = 0;
        #1;
        check("t2_stored", RdData[31:0], 32'd102);
        step();

        // 3: writes to the zero register are dropped
        WrEn = 1; WrAddr = 5'd31; WrData = 32'hDEAD; RdAddr = {5'd31, 5'd31}; DbgAddr = 5'd31;
        #1;
        check("t3_rd_zero", RdData[31:0], 32'h0);
        step();
        WrEn = 0;
        #1;
        check("t3_dbg_zero", DbgData, 32'h0);
        step();

        // 4: save collides with a write to SAVE_REG; save wins
        SaveReq = 1; SavePC = 32'h40; WrEn = 1; WrAddr = 5'd30; WrData = 32'h99;
        RdAddr = {5'd29, 5'd30}; DbgAddr = 5'd30;
        #1;
        check("t4_bypass_pc", RdData[31:0], 32'h40);
        step();
        SaveReq = 0; WrEn = 0;
        #1;
        check("t4_ack", {31'b0, SaveAck}, 32'h1);
        check("t4_r30", DbgData, 32'h40);
        step();
        step();

        // 5: fill, clear, verify ignored traffic and sweep length
        for (int i = 0; i < 32; i++) begin
            WrEn = 1; WrAddr = 5'(i); WrData = $urandom; RdAddr = {5'(i), 5'(i)}; DbgAddr = 5'(i);
            step();
        end
        WrEn = 0; ClearReq = 1;
        step();
        ClearReq = 0;
        busy_cycles = 0;
        while (Busy && busy_cycles < 40) begin
            busy_cycles++;
            WrEn = 1'($urandom); WrAddr = 5'($urandom); WrData = $urandom;
            ClearReq = 1'($urandom); RdAddr = {5'($urandom), WrAddr}; DbgAddr = 5'($urandom);
            step();
        end
        check("t5_busy_len", busy_cycles, 32);
        WrEn = 0; ClearReq = 0;
        for (int i = 0; i < 32; i++) begin
            RdAddr = {5'(i), 5'(i)}; DbgAddr = 5'(i);
            #1;
            check("t5_zero", DbgData, 32'h0);
            step();
        end

        // 6: reset in the middle of a clear while a save is held
        for (int i = 0; i < 32; i++) begin
            WrEn = 1; WrAddr = 5'(i); WrData = $urandom;
            step();
        end
        WrEn = 0; ClearReq = 1;
        step();
        ClearReq = 0; SaveReq = 1; SavePC = 32'h1234_5678;
        for (int i = 0; i < 10; i++) step();
        do_reset();
        step();
        SaveReq = 0; DbgAddr = 5'd30;
        #1;
        check("t6_r30", DbgData, 32'h1234_5678);
        check("t6_ack", {31'b0, SaveAck}, 32'h1);
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            WrEn     = 1'($urandom);
            WrAddr   = 5'($urandom);
            WrData   = $urandom;
            SaveReq  = ($urandom_range(0, 3) == 0);
            SavePC   = $urandom;
            ClearReq = ($urandom_range(0, 63) == 0);
            RdAddr   = {5'($urandom), ($urandom_range(0, 1) == 0) ? WrAddr : 5'($urandom)};
            DbgAddr  = 5'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
